// File: rtl/stream_mux_rr.sv
// N-to-1 valid/ready stream mux with a registered output stage; MODE selects external-select or round-robin grant.
// Optional packet lock (grant held from first beat to in_last) enabled by defining STREAM_MUX_LOCK_EN.
module stream_mux_rr #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 4,
  parameter int MODE   = 0,
  localparam int SEL_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH-1:0]        in_last,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic                     out_last,
  output logic [SEL_W-1:0]         out_ch,
  input  logic                     out_ready
);

  logic [DATA_W-1:0] ch_data [NUM_CH];
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q, out_last_q;
  logic [SEL_W-1:0]  out_ch_q;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0]  grant_ch, cand;
  logic              grant_valid, load_en, xfer, adv;
  int                idx;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_data[i] = in_data[i*DATA_W +: DATA_W];
  end

  assign load_en = !out_valid_q || out_ready;
  assign xfer    = load_en && grant_valid;

`ifdef STREAM_MUX_LOCK_EN
  logic             lock_q, lock_d;
  logic [SEL_W-1:0] lock_ch_q, lock_ch_d;

  always_comb begin
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    if (xfer) begin
      lock_d    = !in_last[grant_ch];
      lock_ch_d = grant_ch;
    end
  end

  // Pointer moves only when a packet closes, so the next packet starts after g.
  assign adv = in_last[grant_ch];
`else
  assign adv = 1'b1;
`endif

  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = '0;
    idx         = 0;
    cand        = '0;
    if (MODE == 0) begin
      if (int'(sel) < NUM_CH) begin
        grant_ch    = sel;
        grant_valid = in_valid[sel];
      end
    end else begin
      // Scan backwards so the last hit is the first valid channel from rr_ptr.
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
        cand = SEL_W'(idx);
        if (in_valid[cand]) begin
          grant_valid = 1'b1;
          grant_ch    = cand;
        end
      end
    end
`ifdef STREAM_MUX_LOCK_EN
    if (lock_q) begin
      grant_ch    = lock_ch_q;
      grant_valid = in_valid[lock_ch_q];
    end
`endif
  end

  always_comb begin
    in_ready = '0;
    if (xfer && !reset) in_ready[grant_ch] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (MODE != 0 && xfer && adv)
      rr_ptr_d = (int'(grant_ch) == NUM_CH - 1) ? '0 : grant_ch + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      if (load_en) begin
        out_valid_q <= grant_valid;
        if (grant_valid) begin
          out_data_q <= ch_data[grant_ch];
          out_last_q <= in_last[grant_ch];
          out_ch_q   <= grant_ch;
        end
      end
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef STREAM_MUX_LOCK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
    end
  end
`endif

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;

endmodule
